// File: rtl/duckhunt_pkg.sv
// rtl/duckhunt_pkg.sv - shared DuckHunt widths and firing state encoding
package duckhunt_pkg;

    // Default screen coordinate widths shared by the bird, player and firing blocks
    localparam int DH_X_W = 8;
    localparam int DH_Y_W = 7;

    // Firing state encoding
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SCAN_ENC   = 2'd1;
    localparam logic [1:0] ST_REPORT_ENC = 2'd2;
    localparam logic [1:0] ST_RELOAD_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        SCAN   = ST_SCAN_ENC,
        REPORT = ST_REPORT_ENC,
        RELOAD = ST_RELOAD_ENC
    } fire_state_t;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - 1-D inclusive interval overlap of two boxes
//   a       : start of box A (side A_BOX)
//   b       : start of box B (side B_BOX)
//   overlap : the closed intervals [a, a+A_BOX-1] and [b, b+B_BOX-1] intersect
module box_overlap #(
    parameter int W     = 8,
    parameter int A_BOX = 3,
    parameter int B_BOX = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         overlap
);

    localparam logic [W:0] A_SPAN = (W+1)'(A_BOX - 1);
    localparam logic [W:0] B_SPAN = (W+1)'(B_BOX - 1);

    // One extra bit so a box hanging off the right/bottom edge never wraps to 0
    logic [W:0] a_ext;
    logic [W:0] b_ext;
    logic [W:0] a_end;
    logic [W:0] b_end;

    assign a_ext   = {1'b0, a};
    assign b_ext   = {1'b0, b};
    assign a_end   = a_ext + A_SPAN;
    assign b_end   = b_ext + B_SPAN;
    assign overlap = (a_ext <= b_end) && (b_ext <= a_end);

endmodule

// File: rtl/firing_unit.sv
// rtl/firing_unit.sv - shot resolution: magazine, per-bird hit scan, timed reload
//   clk, reset_n      : clock, asynchronous active-low reset
//   fire, reload      : shot / reload requests from the control FSM
//   x_player,y_player : crosshair top-left
//   bird_x,bird_y     : packed bird top-left positions, bird i at [i*W +: W]
//   bird_alive        : per-bird alive flags
//   remaining_shots   : shots left in the magazine
//   busy, reloading   : status (busy in SCAN/REPORT/RELOAD, reloading in RELOAD)
//   shot_valid        : one-cycle pulse, hit_mask/hit_any updated
//   hit_mask, hit_any : result of the last resolved shot
//   dry_fire          : one-cycle pulse on fire with an empty magazine
module firing_unit
    import duckhunt_pkg::*;
#(
    parameter int X_W           = DH_X_W,
    parameter int Y_W           = DH_Y_W,
    parameter int NUM_BIRDS     = 2,
    parameter int MAG_SIZE      = 3,
    parameter int PLAYER_BOX    = 3,
    parameter int BIRD_BOX      = 4,
    parameter int RELOAD_CYCLES = 25000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           fire,
    input  logic                           reload,
    input  logic [X_W-1:0]                 x_player,
    input  logic [Y_W-1:0]                 y_player,
    input  logic [NUM_BIRDS*X_W-1:0]       bird_x,
    input  logic [NUM_BIRDS*Y_W-1:0]       bird_y,
    input  logic [NUM_BIRDS-1:0]           bird_alive,
    output logic [$clog2(MAG_SIZE+1)-1:0]  remaining_shots,
    output logic                           busy,
    output logic                           reloading,
    output logic                           shot_valid,
    output logic [NUM_BIRDS-1:0]           hit_mask,
    output logic                           hit_any,
    output logic                           dry_fire
);

    localparam int SHOT_W = $clog2(MAG_SIZE + 1);
    localparam int IDX_W  = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
    localparam int CNT_W  = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;

    localparam logic [SHOT_W-1:0] MAG_FULL    = SHOT_W'(MAG_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_BIRDS - 1);
    localparam logic [CNT_W-1:0]  RELOAD_LAST = CNT_W'(RELOAD_CYCLES - 1);

    fire_state_t                state;
    logic [IDX_W-1:0]           scan_idx;
    logic [CNT_W-1:0]           reload_cnt;
    logic [NUM_BIRDS-1:0]       acc;

    // Snapshot taken when a shot is accepted; the scan never looks at live inputs
    logic [X_W-1:0]             xp_q;
    logic [Y_W-1:0]             yp_q;
    logic [NUM_BIRDS*X_W-1:0]   bx_q;
    logic [NUM_BIRDS*Y_W-1:0]   by_q;
    logic [NUM_BIRDS-1:0]       alive_q;

    logic [X_W-1:0]             cur_bx;
    logic [Y_W-1:0]             cur_by;
    logic                       cur_alive;
    logic                       x_ovl;
    logic                       y_ovl;
    logic                       cur_hit;

    always_comb begin
        cur_bx    = '0;
        cur_by    = '0;
        cur_alive = 1'b0;
        for (int i = 0; i < NUM_BIRDS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_bx    = bx_q[i*X_W +: X_W];
                cur_by    = by_q[i*Y_W +: Y_W];
                cur_alive = alive_q[i];
            end
        end
    end

    box_overlap #(
        .W     (X_W),
        .A_BOX (PLAYER_BOX),
        .B_BOX (BIRD_BOX)
    ) u_x_overlap (
        .a       (xp_q),
        .b       (cur_bx),
        .overlap (x_ovl)
    );

    box_overlap #(
        .W     (Y_W),
        .A_BOX (PLAYER_BOX),
        .B_BOX (BIRD_BOX)
    ) u_y_overlap (
        .a       (yp_q),
        .b       (cur_by),
        .overlap (y_ovl)
    );

    assign cur_hit = cur_alive & x_ovl & y_ovl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            scan_idx        <= '0;
            reload_cnt      <= '0;
            acc             <= '0;
            xp_q            <= '0;
            yp_q            <= '0;
            bx_q            <= '0;
            by_q            <= '0;
            alive_q         <= '0;
            remaining_shots <= MAG_FULL;
            busy            <= 1'b0;
            reloading       <= 1'b0;
            shot_valid      <= 1'b0;
            hit_mask        <= '0;
            hit_any         <= 1'b0;
            dry_fire        <= 1'b0;
        end else begin
            shot_valid <= 1'b0;
            dry_fire   <= 1'b0;

            case (state)
                IDLE: begin
                    // fire takes priority; a simultaneous reload is dropped
                    if (fire) begin
                        if (remaining_shots != '0) begin
                            xp_q            <= x_player;
                            yp_q            <= y_player;
                            bx_q            <= bird_x;
                            by_q            <= bird_y;
                            alive_q         <= bird_alive;
                            remaining_shots <= remaining_shots - SHOT_W'(1);
                            acc             <= '0;
                            scan_idx        <= '0;
                            busy            <= 1'b1;
                            state           <= SCAN;
                        end else begin
                            dry_fire <= 1'b1;
                        end
                    end else if (reload && (remaining_shots != MAG_FULL)) begin
                        reload_cnt <= RELOAD_LAST;
                        busy       <= 1'b1;
                        reloading  <= 1'b1;
                        state      <= RELOAD;
                    end
                end

                SCAN: begin
                    if (cur_hit) begin
                        acc[scan_idx] <= 1'b1;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= REPORT;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end

                REPORT: begin
                    hit_mask   <= acc;
                    hit_any    <= |acc;
                    shot_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                RELOAD: begin
                    // Counter runs RELOAD_CYCLES-1 down to 0: RELOAD_CYCLES cycles in total
                    if (reload_cnt == '0) begin
                        remaining_shots <= MAG_FULL;
                        reloading       <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        reload_cnt <= reload_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firing_unit.sv
// tb/tb_firing_unit.sv - self-checking bench for firing_unit
module tb_firing_unit;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int NB  = 2;
    localparam int MAG = 3;
    localparam int PB  = 3;
    localparam int BB  = 4;
    localparam int RC  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              fire;
    logic              reload;
    logic [X_W-1:0]    x_player;
    logic [Y_W-1:0]    y_player;
    logic [NB*X_W-1:0] bird_x;
    logic [NB*Y_W-1:0] bird_y;
    logic [NB-1:0]     bird_alive;
    logic [1:0]        remaining_shots;
    logic              busy;
    logic              reloading;
    logic              shot_valid;
    logic [NB-1:0]     hit_mask;
    logic              hit_any;
    logic              dry_fire;

    int total  = 0;
    int passed = 0;
    int model_shots;
    logic [NB-1:0] model_last_mask;

    firing_unit #(
        .X_W           (X_W),
        .Y_W           (Y_W),
        .NUM_BIRDS     (NB),
        .MAG_SIZE      (MAG),
        .PLAYER_BOX    (PB),
        .BIRD_BOX      (BB),
        .RELOAD_CYCLES (RC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fire            (fire),
        .reload          (reload),
        .x_player        (x_player),
        .y_player        (y_player),
        .bird_x          (bird_x),
        .bird_y          (bird_y),
        .bird_alive      (bird_alive),
        .remaining_shots (remaining_shots),
        .busy            (busy),
        .reloading       (reloading),
        .shot_valid      (shot_valid),
        .hit_mask        (hit_mask),
        .hit_any         (hit_any),
        .dry_fire        (dry_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: inclusive box intersection on unbounded integers (no screen wrap)
    function automatic logic [NB-1:0] model_mask(input int xp, input int yp,
                                                 input logic [NB*X_W-1:0] bx,
                                                 input logic [NB*Y_W-1:0] by,
                                                 input logic [NB-1:0] alive);
        logic [NB-1:0] m;
        int xb;
        int yb;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            xb = int'(bx[i*X_W +: X_W]);
            yb = int'(by[i*Y_W +: Y_W]);
            m[i] = alive[i] && (xp <= xb + BB - 1) && (xb <= xp + PB - 1)
                            && (yp <= yb + BB - 1) && (yb <= yp + PB - 1);
        end
        return m;
    endfunction

    task automatic fire_shot(input string tag, input int xp, input int yp,
                             input logic [NB*X_W-1:0] bx, input logic [NB*Y_W-1:0] by,
                             input logic [NB-1:0] alive, input logic with_reload);
        logic [NB-1:0] exp_mask;
        int lat;
        exp_mask   = model_mask(xp, yp, bx, by, alive);
        x_player   = X_W'(xp);
        y_player   = Y_W'(yp);
        bird_x     = bx;
        bird_y     = by;
        bird_alive = alive;
        fire       = 1'b1;
        reload     = with_reload;
        tick();
        fire   = 1'b0;
        reload = 1'b0;
        model_shots--;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_shots"}, remaining_shots, model_shots);
        // Disturb live inputs: the result must come from the snapshot
        x_player   = X_W'($urandom);
        y_player   = Y_W'($urandom);
        bird_x     = NB*X_W'($urandom);
        bird_y     = NB*Y_W'($urandom);
        bird_alive = NB'($urandom);
        lat = 0;
        while (shot_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, NB + 1);
        check({tag, "_mask"}, hit_mask, exp_mask);
        check({tag, "_any"}, hit_any, |exp_mask);
        check({tag, "_reloading"}, reloading, 0);
        model_last_mask = exp_mask;
        tick();
        check({tag, "_valid_pulse"}, shot_valid, 0);
    endtask

    task automatic do_reload(input string tag);
        int n;
        logic bad;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        fire   = 1'b1;
        n      = 0;
        bad    = 1'b0;
        while (reloading === 1'b1 && n < 30) begin
            if (dry_fire !== 1'b0 || shot_valid !== 1'b0) bad = 1'b1;
            tick();
            n++;
        end
        fire = 1'b0;
        model_shots = MAG;
        check({tag, "_cycles"}, n, RC);
        check({tag, "_quiet"}, bad, 0);
        check({tag, "_shots"}, remaining_shots, MAG);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_shots"}, remaining_shots, MAG);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_reloading"}, reloading, 0);
        check({tag, "_valid"}, shot_valid, 0);
        check({tag, "_mask"}, hit_mask, 0);
        check({tag, "_any"}, hit_any, 0);
        check({tag, "_dry"}, dry_fire, 0);
    endtask

    initial begin
        logic seen;
        int xp;
        int yp;
        logic [NB*X_W-1:0] bx;
        logic [NB*Y_W-1:0] by;

        reset_n    = 1'b0;
        fire       = 1'b0;
        reload     = 1'b0;
        x_player   = '0;
        y_player   = '0;
        bird_x     = '0;
        bird_y     = '0;
        bird_alive = '0;
        model_shots     = MAG;
        model_last_mask = '0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Directed shots
        fire_shot("direct_hit", 10, 10, {8'd100, 8'd11}, {7'd50, 7'd11}, 2'b11, 1'b0);
        fire_shot("edge_gap", 7, 20, {8'd100, 8'd10}, {7'd50, 7'd20}, 2'b11, 1'b0);
        fire_shot("no_wrap", 250, 5, {8'd100, 8'd0}, {7'd50, 7'd5}, 2'b11, 1'b0);

        // Empty magazine
        check("empty_shots", remaining_shots, 0);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("dry_pulse", dry_fire, 1);
        check("dry_no_valid", shot_valid, 0);
        check("dry_busy", busy, 0);
        check("dry_shots", remaining_shots, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (shot_valid !== 1'b0 || dry_fire !== 1'b0) seen = 1'b1;
        end
        check("dry_after", seen, 0);

        do_reload("reload_empty");

        // Reload with a full magazine is ignored
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_full_ignored", reloading, 0);
        check("reload_full_busy", busy, 0);
        tick();
        check("reload_full_shots", remaining_shots, MAG);

        fire_shot("dead_bird", 20, 20, {8'd21, 8'd19}, {7'd21, 7'd19}, 2'b10, 1'b0);
        fire_shot("fire_reload", 30, 30, {8'd32, 8'd29}, {7'd40, 7'd31}, 2'b11, 1'b1);
        check("fire_reload_no_reload", reloading, 0);

        // Randomised shots near the crosshair
        for (int k = 0; k < 16; k++) begin
            if (model_shots == 0) do_reload("reload_rand");
            xp = int'($urandom_range(0, 255));
            yp = int'($urandom_range(0, 127));
            for (int b = 0; b < NB; b++) begin
                bx[b*X_W +: X_W] = X_W'(xp + int'($urandom_range(0, 12)) - 6);
                by[b*Y_W +: Y_W] = Y_W'(yp + int'($urandom_range(0, 12)) - 6);
            end
            fire_shot("random", xp, yp, bx, by, NB'($urandom), 1'($urandom));
        end

        // Reset in the middle of a scan
        if (model_shots == 0) do_reload("reload_pre_scan");
        fire_shot("pre_reset_hit", 40, 40, {8'd41, 8'd39}, {7'd41, 7'd39}, 2'b11, 1'b0);
        check("pre_reset_mask", hit_mask, 2'b11);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check("scan_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_scan");
        tick();
        reset_n = 1'b1;
        model_shots = MAG;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (shot_valid !== 1'b0) seen = 1'b1;
        end
        check("reset_scan_no_report", seen, 0);

        // Reset in the middle of a reload
        fire_shot("pre_reload", 60, 60, {8'd0, 8'd0}, {7'd0, 7'd0}, 2'b11, 1'b0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_started", reloading, 1);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_reload");
        tick();
        reset_n = 1'b1;
        model_shots = MAG;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (shot_valid !== 1'b0 || reloading !== 1'b0) seen = 1'b1;
        end
        check("reset_reload_idle", seen, 0);
        check("reset_reload_shots", remaining_shots, MAG);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
